uart_rx_param: RTL

Parametrised UART receiver for the UART interface datapath. It takes the serial line `rxd` and an oversampling enable `baud_tick`, and delivers one parallel word per frame with a one-cycle `rx_valid` strobe plus parity, framing and break status. It generalises the fixed 8-bit, 16x receiver: data width, parity mode, stop-bit count and oversampling ratio are configurable. It adds input synchronisation, 3-sample majority voting, false-start rejection and break detection.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sampler.sv | 42 ++++
 rtl/uart_rx_param.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  // Total baud ticks occupied by one frame (start + data + parity + stop bits).
  function automatic int frame_ticks(int data_bits, int parity_en, int stop_bits, int oversample);
    return (1 + data_bits + parity_en + stop_bits) * oversample;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop input synchroniser plus 3-sample majority voter around the bit centre.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             baud_tick,
  input  logic             rxd,
  input  logic [CNT_W-1:0] cnt,
  output logic             rxs,
  output logic             vote
);

  localparam int M = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP1 = CNT_W'(M);

  logic sync1_reg;
  logic sync2_reg;
  logic samp0_reg;
  logic samp1_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      samp0_reg <= 1'b1;
      samp1_reg <= 1'b1;
    end else begin
      sync1_reg <= rxd;
      sync2_reg <= sync1_reg;
      if (baud_tick && cnt == CNT_SAMP0) samp0_reg <= sync2_reg;
      if (baud_tick && cnt == CNT_SAMP1) samp1_reg <= sync2_reg;
    end
  end

  assign rxs = sync2_reg;
  // Third sample is the live value; the vote is only consumed on the cnt = M+1 tick.
  assign vote = (samp0_reg & samp1_reg) | (samp0_reg & sync2_reg) | (samp1_reg & sync2_reg);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: FSM, tick/bit counters, shift register and frame status.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 break_detect,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_VOTE = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic ODD_MODE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  rx_state_t state_reg;
  rx_state_t state_next;

  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 xor_reg;
  logic                 par_err_reg;
  logic                 par_zero_reg;
  logic                 frame_err_reg;
  logic                 brk_reg;
  logic                 armed_reg;

  logic rxs;
  logic vote;
  logic vote_tick;
  logic end_tick;
  logic start_go;
  logic complete;
  logic stop_ferr;
  logic stop_brk;

  uart_rx_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .CNT_W     (CNT_W)
  ) sampler (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(baud_tick),
    .rxd      (rxd),
    .cnt      (cnt_reg),
    .rxs      (rxs),
    .vote     (vote)
  );

  assign vote_tick = baud_tick && (cnt_reg == CNT_VOTE);
  assign end_tick  = baud_tick && (cnt_reg == CNT_LAST);
  assign start_go  = baud_tick && !rxs && armed_reg;
  assign complete  = (state_reg == STOP) && vote_tick && (idx_reg == IDX_STOP_LAST);

  // Break is judged on the first stop bit only; later stop bits just add to the frame error.
  assign stop_ferr = frame_err_reg | ~vote;
  assign stop_brk  = (idx_reg == '0) ? ((shift_reg == '0) && par_zero_reg && !vote) : brk_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_go) state_next = START;
      START: begin
        if (vote_tick && vote) state_next = IDLE;
        else if (end_tick)     state_next = DATA;
      end
      DATA: begin
        if (end_tick && idx_reg == IDX_DATA_LAST)
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY:  if (end_tick) state_next = STOP;
      STOP:    if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      xor_reg       <= 1'b0;
      par_err_reg   <= 1'b0;
      par_zero_reg  <= 1'b1;
      frame_err_reg <= 1'b0;
      brk_reg       <= 1'b0;
      armed_reg     <= 1'b1;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state_reg == IDLE && rxs) armed_reg <= 1'b1;
      if (state_reg != IDLE && baud_tick) cnt_reg <= end_tick ? '0 : cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (start_go) begin
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            xor_reg       <= 1'b0;
            par_err_reg   <= 1'b0;
            par_zero_reg  <= 1'b1;
            frame_err_reg <= 1'b0;
            brk_reg       <= 1'b0;
          end
        end
        DATA: begin
          if (vote_tick) begin
            shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
            xor_reg   <= xor_reg ^ vote;
          end
          if (end_tick) idx_reg <= (idx_reg == IDX_DATA_LAST) ? '0 : idx_reg + 1'b1;
        end
        PARITY: begin
          if (vote_tick) begin
            par_err_reg  <= (vote != (xor_reg ^ ODD_MODE));
            par_zero_reg <= !vote;
          end
        end
        STOP: begin
          if (complete) begin
            rx_data      <= shift_reg;
            parity_error <= par_err_reg;
            frame_error  <= stop_ferr;
            break_detect <= stop_brk;
            rx_valid     <= 1'b1;
            // A bad stop bit disarms until the line is seen high, so a held-low line reports once.
            if (stop_ferr) armed_reg <= 1'b0;
          end else if (vote_tick) begin
            frame_err_reg <= stop_ferr;
            brk_reg       <= stop_brk;
          end
          if (end_tick) idx_reg <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
